// File: rtl/reg_file_param.sv
// Parametrised 2-read/1-write register file with registered inputs, optional write-through
// bypass, optional hardwired-zero R0 and a sequenced clear sweep.
module reg_file_param #(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 4,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  input  logic             clr,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             busy,
  output logic             wr_drop
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state, state_nx;
  logic [AW-1:0]    ptr, ptr_nx;

  logic             wr_en_q;
  logic [AW-1:0]    wr_addr_q;
  logic [WIDTH-1:0] wr_data_q;
  logic [AW-1:0]    rd_addr_a_q;
  logic [AW-1:0]    rd_addr_b_q;
  logic             clr_q;

  logic [WIDTH-1:0] mem [DEPTH];

  logic wr_is_r0;
  logic wr_commit;
  logic rd_zero_a, rd_zero_b;
  logic byp_a, byp_b;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      clr_q       <= 1'b0;
    end else begin
      wr_en_q     <= wr_en;
      wr_addr_q   <= wr_addr;
      wr_data_q   <= wr_data;
      rd_addr_a_q <= rd_addr_a;
      rd_addr_b_q <= rd_addr_b;
      clr_q       <= clr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    case (state)
      IDLE: begin
        if (clr_q) begin
          state_nx = CLEAR;
          ptr_nx   = '0;
        end
      end
      CLEAR: begin
        if (ptr == AW'(DEPTH - 1)) begin
          state_nx = IDLE;
          ptr_nx   = '0;
        end else begin
          ptr_nx = ptr + AW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        ptr_nx   = '0;
      end
    endcase
  end

  assign busy      = (state == CLEAR);
  assign wr_is_r0  = (ZERO_REG != 0) && (wr_addr_q == '0);
  assign wr_commit = wr_en_q && !busy && !wr_is_r0;
  assign wr_drop   = wr_en_q && busy && !wr_is_r0;

  // NOTE: the array is reset explicitly because reads must return 0 straight out of reset;
  // this rules out mapping it onto a plain RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (busy) begin
      mem[ptr] <= '0;
    end else if (wr_commit) begin
      mem[wr_addr_q] <= wr_data_q;
    end
  end

  // Forwarding only ever sees committed writes, so sweep and R0 discards never leak through.
  assign rd_zero_a = (ZERO_REG != 0) && (rd_addr_a_q == '0);
  assign rd_zero_b = (ZERO_REG != 0) && (rd_addr_b_q == '0);
  assign byp_a     = (BYPASS != 0) && wr_commit && (wr_addr_q == rd_addr_a_q);
  assign byp_b     = (BYPASS != 0) && wr_commit && (wr_addr_q == rd_addr_b_q);

  assign rd_data_a = rd_zero_a ? '0 : (byp_a ? wr_data_q : mem[rd_addr_a_q]);
  assign rd_data_b = rd_zero_b ? '0 : (byp_b ? wr_data_q : mem[rd_addr_b_q]);

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default, no-bypass and zero-register variants share stimulus.
module tb_reg_file_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd_addr_a;
  logic [1:0] rd_addr_b;
  logic       clr;

  logic [7:0] rd_data_a, rd_data_b;
  logic       busy, wr_drop;
  logic [7:0] nb_rd_a, nb_rd_b;
  logic       nb_busy, nb_wr_drop;
  logic [7:0] z_rd_a, z_rd_b;
  logic       z_busy, z_wr_drop;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reg_file_param dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .clr(clr),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .busy(busy), .wr_drop(wr_drop)
  );

  reg_file_param #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .clr(clr),
    .rd_data_a(nb_rd_a), .rd_data_b(nb_rd_b), .busy(nb_busy), .wr_drop(nb_wr_drop)
  );

  reg_file_param #(.ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .clr(clr),
    .rd_data_a(z_rd_a), .rd_data_b(z_rd_b), .busy(z_busy), .wr_drop(z_wr_drop)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; clr = 1'b0;
    cycle(); cycle();
    vectors++; if (rd_data_a !== 8'h00) begin miscompares++; $display("FAIL reset_a got=%h exp=%h", rd_data_a, 8'h00); end
    vectors++; if (rd_data_b !== 8'h00) begin miscompares++; $display("FAIL reset_b got=%h exp=%h", rd_data_b, 8'h00); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (wr_drop !== 1'b0) begin miscompares++; $display("FAIL reset_wr_drop got=%b exp=0", wr_drop); end
    rst_n = 1'b1;
    // traffic, then reset asserted between edges
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h5A; rd_addr_a = 2'd1; rd_addr_b = 2'd1;
    cycle();
    vectors++; if (rd_data_a !== 8'h5A) begin miscompares++; $display("FAIL pre_reset_byp got=%h exp=%h", rd_data_a, 8'h5A); end
    cycle();
    vectors++; if (nb_rd_a !== 8'h5A) begin miscompares++; $display("FAIL pre_reset_nb got=%h exp=%h", nb_rd_a, 8'h5A); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (rd_data_a !== 8'h00) begin miscompares++; $display("FAIL async_reset_a got=%h exp=%h", rd_data_a, 8'h00); end
    vectors++; if (nb_rd_b !== 8'h00) begin miscompares++; $display("FAIL async_reset_nb_b got=%h exp=%h", nb_rd_b, 8'h00); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL async_reset_busy got=%b exp=0", busy); end
    wr_en = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_addr_a = 2'(i); rd_addr_b = 2'(i);
      cycle();
      vectors++; if (nb_rd_a !== 8'h00) begin miscompares++; $display("FAIL post_reset_a[%0d] got=%h exp=%h", i, nb_rd_a, 8'h00); end
      vectors++; if (nb_rd_b !== 8'h00) begin miscompares++; $display("FAIL post_reset_b[%0d] got=%h exp=%h", i, nb_rd_b, 8'h00); end
    end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'hA5; rd_addr_a = 2'd0; rd_addr_b = 2'd0;
    cycle();
    wr_en = 1'b0; rd_addr_a = 2'd2; rd_addr_b = 2'd2;
    cycle();
    vectors++; if (rd_data_a !== 8'hA5) begin miscompares++; $display("FAIL wr_rd_a got=%h exp=%h", rd_data_a, 8'hA5); end
    vectors++; if (rd_data_b !== 8'hA5) begin miscompares++; $display("FAIL wr_rd_b got=%h exp=%h", rd_data_b, 8'hA5); end
    vectors++; if (nb_rd_a !== 8'hA5) begin miscompares++; $display("FAIL wr_rd_nb_a got=%h exp=%h", nb_rd_a, 8'hA5); end
    vectors++; if (z_rd_b !== 8'hA5) begin miscompares++; $display("FAIL wr_rd_z_b got=%h exp=%h", z_rd_b, 8'hA5); end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h3C; rd_addr_a = 2'd1; rd_addr_b = 2'd2;
    cycle();
    vectors++; if (rd_data_a !== 8'h3C) begin miscompares++; $display("FAIL byp_a got=%h exp=%h", rd_data_a, 8'h3C); end
    vectors++; if (rd_data_b !== 8'hA5) begin miscompares++; $display("FAIL byp_b_other got=%h exp=%h", rd_data_b, 8'hA5); end
    vectors++; if (nb_rd_a !== 8'h00) begin miscompares++; $display("FAIL nobyp_old got=%h exp=%h", nb_rd_a, 8'h00); end
    vectors++; if (z_rd_a !== 8'h3C) begin miscompares++; $display("FAIL byp_z got=%h exp=%h", z_rd_a, 8'h3C); end
    wr_en = 1'b0; rd_addr_b = 2'd1;
    cycle();
    vectors++; if (nb_rd_a !== 8'h3C) begin miscompares++; $display("FAIL nobyp_new got=%h exp=%h", nb_rd_a, 8'h3C); end
    vectors++; if (rd_data_b !== 8'h3C) begin miscompares++; $display("FAIL byp_held_b got=%h exp=%h", rd_data_b, 8'h3C); end
  endtask

  task automatic test_clear();
    logic [7:0] fill [4];
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = fill[i];
      cycle();
    end
    wr_en = 1'b0;
    cycle();
    clr = 1'b1;
    cycle();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL clr_capture_busy got=%b exp=0", busy); end
    clr = 1'b0; rd_addr_a = 2'd0; rd_addr_b = 2'd1;
    cycle();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL sweep_start_busy got=%b exp=1", busy); end
    vectors++; if (rd_data_a !== 8'h11) begin miscompares++; $display("FAIL sweep_r0_intact got=%h exp=%h", rd_data_a, 8'h11); end
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h77;
    for (int k = 0; k < 4; k++) begin
      cycle();
      vectors++; if (rd_data_a !== 8'h00) begin miscompares++; $display("FAIL sweep_cleared[%0d] got=%h exp=%h", k, rd_data_a, 8'h00); end
      if (k < 3) begin
        vectors++; if (rd_data_b !== fill[k+1]) begin miscompares++; $display("FAIL sweep_next_intact[%0d] got=%h exp=%h", k + 1, rd_data_b, fill[k+1]); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL sweep_busy[%0d] got=%b exp=1", k, busy); end
      end else begin
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sweep_end_busy got=%b exp=0", busy); end
      end
      if (k == 0) begin
        vectors++; if (wr_drop !== 1'b1) begin miscompares++; $display("FAIL wr_drop_set got=%b exp=1", wr_drop); end
        wr_en = 1'b0;
      end else if (k == 1) begin
        vectors++; if (wr_drop !== 1'b0) begin miscompares++; $display("FAIL wr_drop_one_cycle got=%b exp=0", wr_drop); end
      end
      rd_addr_a = 2'(k + 1); rd_addr_b = (k < 2) ? 2'(k + 2) : 2'd3;
    end
    rd_addr_a = 2'd3;
    cycle();
    vectors++; if (rd_data_a !== 8'h00) begin miscompares++; $display("FAIL r3_after_sweep got=%h exp=%h", rd_data_a, 8'h00); end
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hFF; rd_addr_a = 2'd0; rd_addr_b = 2'd0;
    cycle();
    vectors++; if (z_rd_a !== 8'h00) begin miscompares++; $display("FAIL zero_no_byp got=%h exp=%h", z_rd_a, 8'h00); end
    vectors++; if (rd_data_a !== 8'hFF) begin miscompares++; $display("FAIL r0_byp_default got=%h exp=%h", rd_data_a, 8'hFF); end
    wr_en = 1'b0;
    cycle();
    vectors++; if (z_rd_a !== 8'h00) begin miscompares++; $display("FAIL zero_after_wr got=%h exp=%h", z_rd_a, 8'h00); end
    vectors++; if (z_rd_b !== 8'h00) begin miscompares++; $display("FAIL zero_after_wr_b got=%h exp=%h", z_rd_b, 8'h00); end
    vectors++; if (nb_rd_a !== 8'hFF) begin miscompares++; $display("FAIL r0_stored_nb got=%h exp=%h", nb_rd_a, 8'hFF); end
  endtask

  task automatic test_sweep_reset();
    int busy_cnt;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (busy === 1'b1) busy_cnt++;
      clr = (c == 0);
    end
    vectors++; if (busy_cnt !== 4) begin miscompares++; $display("FAIL busy_len_reclr got=%0d exp=4", busy_cnt); end
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = 8'(i + 1);
      cycle();
    end
    wr_en = 1'b0;
    cycle();
    clr = 1'b1; rd_addr_a = 2'd2; rd_addr_b = 2'd3;
    cycle();
    clr = 1'b0;
    cycle(); cycle(); cycle();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_sweep_busy got=%b exp=1", busy); end
    vectors++; if (rd_data_a !== 8'h03) begin miscompares++; $display("FAIL mid_sweep_r2 got=%h exp=%h", rd_data_a, 8'h03); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got=%b exp=0", busy); end
    vectors++; if (rd_data_b !== 8'h00) begin miscompares++; $display("FAIL abort_rd_b got=%h exp=%h", rd_data_b, 8'h00); end
    cycle();
    rst_n = 1'b1;
    cycle();
    vectors++; if (rd_data_a !== 8'h00) begin miscompares++; $display("FAIL abort_r2 got=%h exp=%h", rd_data_a, 8'h00); end
    vectors++; if (rd_data_b !== 8'h00) begin miscompares++; $display("FAIL abort_r3 got=%h exp=%h", rd_data_b, 8'h00); end
    cycle();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle got=%b exp=0", busy); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_zero_reg();
    test_sweep_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
